// File: rtl/soma_bfs_run_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// soma_bfs_run_ctrl_if: CSR/AFU-side signal bundle of the BFS launch sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
interface soma_bfs_run_ctrl_if;
  logic        run_req;
  logic        abort_req;
  logic [31:0] cfg_capacity;
  logic [63:0] cfg_rd_nodes;
  logic [63:0] cfg_rd_edges;
  logic [63:0] cfg_rd_dist;
  logic [63:0] cfg_wr_dist;
  logic [63:0] cfg_rd_wl;
  logic [63:0] cfg_wr_wl;

  logic        start_worklistServiceMod;
  logic        start_afuBFS;
  logic [31:0] setCapacity_worklistServiceMod;
  logic [63:0] setRd_addr_readNodes;
  logic [63:0] setRd_addr_readEdges;
  logic [63:0] setRd_addr_readDistance;
  logic [63:0] setWr_addr_writeDistance;
  logic [63:0] setRd_addr_readWorklist;
  logic [63:0] setWr_addr_writeWorklist;

  logic        finish_afuBFS;
  logic [63:0] getNodesTchd_afuBFS;

  logic        busy;
  logic        done;
  logic        err_cfg;
  logic        err_timeout;
  logic        aborted;
  logic [63:0] run_cycles;
  logic [63:0] nodes_tchd;

  // Environment side: CSR block plus the AFU completion/status signals.
  modport master (
    output run_req, abort_req, cfg_capacity,
    output cfg_rd_nodes, cfg_rd_edges, cfg_rd_dist, cfg_wr_dist, cfg_rd_wl, cfg_wr_wl,
    output finish_afuBFS, getNodesTchd_afuBFS,
    input  start_worklistServiceMod, start_afuBFS, setCapacity_worklistServiceMod,
    input  setRd_addr_readNodes, setRd_addr_readEdges, setRd_addr_readDistance,
    input  setWr_addr_writeDistance, setRd_addr_readWorklist, setWr_addr_writeWorklist,
    input  busy, done, err_cfg, err_timeout, aborted, run_cycles, nodes_tchd
  );

  // Sequencer side.
  modport slave (
    input  run_req, abort_req, cfg_capacity,
    input  cfg_rd_nodes, cfg_rd_edges, cfg_rd_dist, cfg_wr_dist, cfg_rd_wl, cfg_wr_wl,
    input  finish_afuBFS, getNodesTchd_afuBFS,
    output start_worklistServiceMod, start_afuBFS, setCapacity_worklistServiceMod,
    output setRd_addr_readNodes, setRd_addr_readEdges, setRd_addr_readDistance,
    output setWr_addr_writeDistance, setRd_addr_readWorklist, setWr_addr_writeWorklist,
    output busy, done, err_cfg, err_timeout, aborted, run_cycles, nodes_tchd
  );
endinterface
`default_nettype wire

// File: rtl/soma_bfs_run_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// soma_bfs_run_ctrl: validates a BFS launch config, pulses WL then AFU start,
// and measures the run. Rev 1.0
// ---------------------------------------------------------------------------
module soma_bfs_run_ctrl #(
  parameter int unsigned WL_SETTLE       = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 0,
  parameter int unsigned ADDR_ALIGN_BITS = 6
) (
  input  logic                clk,
  input  logic                SoftReset,
  soma_bfs_run_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_START_WL  = 3'd2,
    S_SETTLE    = 3'd3,
    S_START_BFS = 3'd4,
    S_RUN       = 3'd5,
    S_FINISH    = 3'd6
  } state_t;

  // SETTLE holds for WL_SETTLE-1 cycles; the counter is loaded with WL_SETTLE-2.
  localparam int unsigned       SETTLE_W    = (WL_SETTLE > 2) ? $clog2(WL_SETTLE - 1) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'((WL_SETTLE >= 2) ? (WL_SETTLE - 2) : 0);
  localparam logic [63:0]       ALIGN_MASK  = (64'd1 << ADDR_ALIGN_BITS) - 64'd1;
  localparam logic [63:0]       TIMEOUT_LIM = 64'(TIMEOUT_CYCLES);

  state_t              state_q, state_d;
  logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
  logic [63:0]         run_cycles_q, run_cycles_d;
  logic [63:0]         nodes_tchd_q, nodes_tchd_d;
  logic                done_q, done_d;
  logic                err_cfg_q, err_cfg_d;
  logic                err_timeout_q, err_timeout_d;
  logic                aborted_q, aborted_d;
  logic [31:0]         capacity_q, capacity_d;
  logic [63:0]         rd_nodes_q, rd_nodes_d;
  logic [63:0]         rd_edges_q, rd_edges_d;
  logic [63:0]         rd_dist_q, rd_dist_d;
  logic [63:0]         wr_dist_q, wr_dist_d;
  logic [63:0]         rd_wl_q, rd_wl_d;
  logic [63:0]         wr_wl_q, wr_wl_d;

  logic                cfg_bad;
  logic [63:0]         run_cycles_inc;

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      state_q       <= S_IDLE;
      settle_cnt_q  <= '0;
      run_cycles_q  <= '0;
      nodes_tchd_q  <= '0;
      done_q        <= 1'b0;
      err_cfg_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      aborted_q     <= 1'b0;
      capacity_q    <= '0;
      rd_nodes_q    <= '0;
      rd_edges_q    <= '0;
      rd_dist_q     <= '0;
      wr_dist_q     <= '0;
      rd_wl_q       <= '0;
      wr_wl_q       <= '0;
    end else begin
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      run_cycles_q  <= run_cycles_d;
      nodes_tchd_q  <= nodes_tchd_d;
      done_q        <= done_d;
      err_cfg_q     <= err_cfg_d;
      err_timeout_q <= err_timeout_d;
      aborted_q     <= aborted_d;
      capacity_q    <= capacity_d;
      rd_nodes_q    <= rd_nodes_d;
      rd_edges_q    <= rd_edges_d;
      rd_dist_q     <= rd_dist_d;
      wr_dist_q     <= wr_dist_d;
      rd_wl_q       <= rd_wl_d;
      wr_wl_q       <= wr_wl_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    settle_cnt_d  = settle_cnt_q;
    run_cycles_d  = run_cycles_q;
    nodes_tchd_d  = nodes_tchd_q;
    done_d        = done_q;
    err_cfg_d     = err_cfg_q;
    err_timeout_d = err_timeout_q;
    aborted_d     = aborted_q;
    capacity_d    = capacity_q;
    rd_nodes_d    = rd_nodes_q;
    rd_edges_d    = rd_edges_q;
    rd_dist_d     = rd_dist_q;
    wr_dist_d     = wr_dist_q;
    rd_wl_d       = rd_wl_q;
    wr_wl_d       = wr_wl_q;

    // Config check runs on the latched copy, so it matches what the AFU sees.
    cfg_bad = ((rd_nodes_q | rd_edges_q | rd_dist_q | wr_dist_q | rd_wl_q | wr_wl_q)
               & ALIGN_MASK) != 64'd0 || capacity_q == 32'd0;
    run_cycles_inc = (&run_cycles_q) ? run_cycles_q : run_cycles_q + 64'd1;

    case (state_q)
      S_IDLE: begin
        if (bus.run_req) begin
          capacity_d    = bus.cfg_capacity;
          rd_nodes_d    = bus.cfg_rd_nodes;
          rd_edges_d    = bus.cfg_rd_edges;
          rd_dist_d     = bus.cfg_rd_dist;
          wr_dist_d     = bus.cfg_wr_dist;
          rd_wl_d       = bus.cfg_rd_wl;
          wr_wl_d       = bus.cfg_wr_wl;
          done_d        = 1'b0;
          err_cfg_d     = 1'b0;
          err_timeout_d = 1'b0;
          aborted_d     = 1'b0;
          state_d       = S_CHECK;
        end
      end
      S_CHECK: begin
        if (cfg_bad) begin
          err_cfg_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          state_d   = S_START_WL;
        end
      end
      S_START_WL: begin
        settle_cnt_d = SETTLE_LOAD;
        state_d      = (WL_SETTLE <= 1) ? S_START_BFS : S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_cnt_q == '0) begin
          state_d = S_START_BFS;
        end else begin
          settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
        end
      end
      S_START_BFS: begin
        run_cycles_d = 64'd1;
        state_d      = S_RUN;
      end
      S_RUN: begin
        run_cycles_d = run_cycles_inc;
        if (bus.finish_afuBFS) begin
          nodes_tchd_d = bus.getNodesTchd_afuBFS;
          state_d      = S_FINISH;
        end else if (TIMEOUT_CYCLES != 0 && run_cycles_inc >= TIMEOUT_LIM) begin
          err_timeout_d = 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides finish/timeout outcomes, but a failed config check wins over it.
    if (bus.abort_req && state_q != S_IDLE && !(state_q == S_CHECK && cfg_bad)) begin
      state_d       = S_IDLE;
      aborted_d     = 1'b1;
      done_d        = done_q;
      err_timeout_d = err_timeout_q;
      nodes_tchd_d  = nodes_tchd_q;
    end
  end

  assign bus.start_worklistServiceMod       = (state_q == S_START_WL);
  assign bus.start_afuBFS                   = (state_q == S_START_BFS);
  assign bus.setCapacity_worklistServiceMod = capacity_q;
  assign bus.setRd_addr_readNodes           = rd_nodes_q;
  assign bus.setRd_addr_readEdges           = rd_edges_q;
  assign bus.setRd_addr_readDistance        = rd_dist_q;
  assign bus.setWr_addr_writeDistance       = wr_dist_q;
  assign bus.setRd_addr_readWorklist        = rd_wl_q;
  assign bus.setWr_addr_writeWorklist       = wr_wl_q;
  assign bus.busy                           = (state_q != S_IDLE);
  assign bus.done                           = done_q;
  assign bus.err_cfg                        = err_cfg_q;
  assign bus.err_timeout                    = err_timeout_q;
  assign bus.aborted                        = aborted_q;
  assign bus.run_cycles                     = run_cycles_q;
  assign bus.nodes_tchd                     = nodes_tchd_q;

endmodule
`default_nettype wire

// File: tb/tb_soma_bfs_run_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_soma_bfs_run_ctrl: directed bench; unit A has no watchdog, unit B a 50-cycle one
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_soma_bfs_run_ctrl;

  logic clk = 1'b0;
  logic soft_reset = 1'b1;
  always #5 clk = ~clk;

  soma_bfs_run_ctrl_if bus_a ();
  soma_bfs_run_ctrl_if bus_b ();

  soma_bfs_run_ctrl #(.WL_SETTLE(4), .TIMEOUT_CYCLES(0), .ADDR_ALIGN_BITS(6)) u_dut_a (
    .clk       (clk),
    .SoftReset (soft_reset),
    .bus       (bus_a)
  );

  soma_bfs_run_ctrl #(.WL_SETTLE(4), .TIMEOUT_CYCLES(50), .ADDR_ALIGN_BITS(6)) u_dut_b (
    .clk       (clk),
    .SoftReset (soft_reset),
    .bus       (bus_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int wl_pulses_a = 0;
  int bfs_pulses_a = 0;

  always @(negedge clk) begin
    if (bus_a.start_worklistServiceMod) wl_pulses_a++;
    if (bus_a.start_afuBFS) bfs_pulses_a++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_a(input logic [63:0] base, input logic [31:0] cap);
    bus_a.cfg_rd_nodes = base;
    bus_a.cfg_rd_edges = base * 2;
    bus_a.cfg_rd_dist  = base * 3;
    bus_a.cfg_wr_dist  = base * 4;
    bus_a.cfg_rd_wl    = base * 5;
    bus_a.cfg_wr_wl    = base * 6;
    bus_a.cfg_capacity = cap;
  endtask

  task automatic pulse_run_a();
    bus_a.run_req = 1'b1;
    step();
    bus_a.run_req = 1'b0;
  endtask

  task automatic wait_pulse_a(input bit bfs, output int n);
    n = 0;
    while (n < 40 && !(bfs ? bus_a.start_afuBFS : bus_a.start_worklistServiceMod)) begin
      step();
      n++;
    end
    if (n >= 40) check(bfs ? "wait_bfs" : "wait_wl", 64'd0, 64'd1);
  endtask

  int n;
  int wl0, bfs0;

  initial begin
    bus_a.run_req = 0; bus_a.abort_req = 0; bus_a.finish_afuBFS = 0;
    bus_a.getNodesTchd_afuBFS = 0;
    cfg_a(64'h1000, 32'd1024);
    bus_b.run_req = 0; bus_b.abort_req = 0; bus_b.finish_afuBFS = 0;
    bus_b.getNodesTchd_afuBFS = 0;
    bus_b.cfg_capacity = 32'd64;
    bus_b.cfg_rd_nodes = 64'h1000; bus_b.cfg_rd_edges = 64'h2000;
    bus_b.cfg_rd_dist  = 64'h3000; bus_b.cfg_wr_dist  = 64'h4000;
    bus_b.cfg_rd_wl    = 64'h5000; bus_b.cfg_wr_wl    = 64'h6000;

    // Reset state
    step(3);
    soft_reset = 1'b0;
    check("rst_busy", bus_a.busy, 64'd0);
    check("rst_done", bus_a.done, 64'd0);
    check("rst_rd_nodes", bus_a.setRd_addr_readNodes, 64'd0);
    check("rst_capacity", bus_a.setCapacity_worklistServiceMod, 64'd0);
    check("rst_run_cycles", bus_a.run_cycles, 64'd0);

    // Nominal run: finish 100 cycles after the AFU pulse
    wl0 = wl_pulses_a; bfs0 = bfs_pulses_a;
    pulse_run_a();
    check("t1_busy_check", bus_a.busy, 64'd1);
    wait_pulse_a(0, n);
    check("t1_check_to_wl", n, 64'd1);
    wait_pulse_a(1, n);
    check("t1_wl_to_bfs", n, 64'd4);
    check("t1_rd_edges", bus_a.setRd_addr_readEdges, 64'h2000);
    check("t1_wr_wl", bus_a.setWr_addr_writeWorklist, 64'h6000);
    check("t1_capacity", bus_a.setCapacity_worklistServiceMod, 64'd1024);
    step(100);
    bus_a.finish_afuBFS = 1'b1; bus_a.getNodesTchd_afuBFS = 64'h2A;
    step();
    bus_a.finish_afuBFS = 1'b0; bus_a.getNodesTchd_afuBFS = 64'h0;
    check("t1_busy_finish", bus_a.busy, 64'd1);
    check("t1_done_early", bus_a.done, 64'd0);
    step();
    check("t1_done", bus_a.done, 64'd1);
    check("t1_busy_fall", bus_a.busy, 64'd0);
    check("t1_run_cycles", bus_a.run_cycles, 64'd101);
    check("t1_nodes", bus_a.nodes_tchd, 64'h2A);
    check("t1_wl_count", wl_pulses_a - wl0, 64'd1);
    check("t1_bfs_count", bfs_pulses_a - bfs0, 64'd1);

    // Config rejection: misaligned address, then zero capacity
    wl0 = wl_pulses_a; bfs0 = bfs_pulses_a;
    cfg_a(64'h1000, 32'd1024);
    bus_a.cfg_rd_edges = 64'h2010;
    pulse_run_a();
    check("t2_busy_check", bus_a.busy, 64'd1);
    check("t2_done_cleared", bus_a.done, 64'd0);
    step();
    check("t2_err_cfg", bus_a.err_cfg, 64'd1);
    check("t2_busy", bus_a.busy, 64'd0);
    check("t2_latched_edges", bus_a.setRd_addr_readEdges, 64'h2010);
    cfg_a(64'h1000, 32'd0);
    pulse_run_a();
    step();
    check("t2_cap0_err_cfg", bus_a.err_cfg, 64'd1);
    check("t2_cap0_busy", bus_a.busy, 64'd0);
    step(6);
    check("t2_no_wl", wl_pulses_a - wl0, 64'd0);
    check("t2_no_bfs", bfs_pulses_a - bfs0, 64'd0);

    // Abort in SETTLE, then abort coincident with finish
    cfg_a(64'h1000, 32'd1024);
    wl0 = wl_pulses_a; bfs0 = bfs_pulses_a;
    pulse_run_a();
    check("t4_err_cfg_cleared", bus_a.err_cfg, 64'd0);
    wait_pulse_a(0, n);
    step();
    bus_a.abort_req = 1'b1;
    step();
    bus_a.abort_req = 1'b0;
    check("t4_aborted", bus_a.aborted, 64'd1);
    check("t4_busy", bus_a.busy, 64'd0);
    step(10);
    check("t4_no_bfs", bfs_pulses_a - bfs0, 64'd0);
    check("t4_one_wl", wl_pulses_a - wl0, 64'd1);
    pulse_run_a();
    check("t4_aborted_cleared", bus_a.aborted, 64'd0);
    wait_pulse_a(1, n);
    step(10);
    bus_a.finish_afuBFS = 1'b1; bus_a.abort_req = 1'b1;
    step();
    bus_a.finish_afuBFS = 1'b0; bus_a.abort_req = 1'b0;
    check("t4_abort_fin_aborted", bus_a.aborted, 64'd1);
    check("t4_abort_fin_busy", bus_a.busy, 64'd0);
    step(2);
    check("t4_abort_fin_done", bus_a.done, 64'd0);

    // run_req during RUN with new config is ignored
    cfg_a(64'h1000, 32'd1024);
    wl0 = wl_pulses_a; bfs0 = bfs_pulses_a;
    pulse_run_a();
    wait_pulse_a(1, n);
    step(5);
    cfg_a(64'h10000, 32'd77);
    pulse_run_a();
    check("t5_rd_nodes_kept", bus_a.setRd_addr_readNodes, 64'h1000);
    check("t5_capacity_kept", bus_a.setCapacity_worklistServiceMod, 64'd1024);
    step(5);
    bus_a.finish_afuBFS = 1'b1;
    step();
    bus_a.finish_afuBFS = 1'b0;
    step();
    check("t5_done", bus_a.done, 64'd1);
    check("t5_run_cycles", bus_a.run_cycles, 64'd12);
    step(10);
    check("t5_wl_count", wl_pulses_a - wl0, 64'd1);
    check("t5_bfs_count", bfs_pulses_a - bfs0, 64'd1);
    check("t5_idle", bus_a.busy, 64'd0);

    // SoftReset mid-run, then a held finish level must not end the next run early
    cfg_a(64'h1000, 32'd1024);
    pulse_run_a();
    wait_pulse_a(1, n);
    step(3);
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    check("t6_busy", bus_a.busy, 64'd0);
    check("t6_rd_nodes", bus_a.setRd_addr_readNodes, 64'd0);
    check("t6_capacity", bus_a.setCapacity_worklistServiceMod, 64'd0);
    check("t6_run_cycles", bus_a.run_cycles, 64'd0);
    bfs0 = bfs_pulses_a;
    step(10);
    check("t6_no_bfs", bfs_pulses_a - bfs0, 64'd0);
    bus_a.finish_afuBFS = 1'b1;
    pulse_run_a();
    step(2);
    check("t6_held_busy", bus_a.busy, 64'd1);
    check("t6_held_done", bus_a.done, 64'd0);
    wait_pulse_a(1, n);
    step(3);
    bus_a.finish_afuBFS = 1'b0;
    check("t6_held_done_after", bus_a.done, 64'd1);
    check("t6_held_run_cycles", bus_a.run_cycles, 64'd2);
    check("t6_bfs_count", bfs_pulses_a - bfs0, 64'd1);

    // Watchdog on unit B
    bus_b.run_req = 1'b1;
    step();
    bus_b.run_req = 1'b0;
    n = 0;
    while (n < 20 && !bus_b.start_afuBFS) begin
      step();
      n++;
    end
    check("t3_bfs_latency", n, 64'd5);
    n = 0;
    while (n < 100 && !bus_b.err_timeout) begin
      step();
      n++;
    end
    check("t3_timeout_latency", n, 64'd50);
    check("t3_run_cycles", bus_b.run_cycles, 64'd50);
    check("t3_done", bus_b.done, 64'd0);
    check("t3_busy", bus_b.busy, 64'd0);
    bus_b.run_req = 1'b1;
    step();
    bus_b.run_req = 1'b0;
    check("t3_rerun_busy", bus_b.busy, 64'd1);
    check("t3_rerun_clear", bus_b.err_timeout, 64'd0);
    bus_b.abort_req = 1'b1;
    step();
    bus_b.abort_req = 1'b0;
    check("t3_rerun_aborted", bus_b.aborted, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
